// File: rtl/ad_capture_ctrl.sv
// Write side of the waveform sample buffer: decimates the ADC stream, keeps a pre-trigger
// history, detects a level/edge trigger, fills the frame and holds it until it has been drawn.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | stopped; address, counters and history cleared
//   S_PRE  | writing the PRE_TRIG samples that precede any trigger
//   S_ARM  | writing circularly, evaluating edge trigger and auto timeout
//   S_POST | writing samples after the trigger until the frame is full
//   S_HOLD | frame complete, no writes, waiting for frame_done
module ad_capture_ctrl #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 10,
   parameter int PRE_TRIG = 256,
   parameter int TIMEOUT  = 65535
) (
   input  logic              ad_clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] ad_data,
   input  logic              run,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_edge,
   input  logic              trig_auto,
   input  logic [9:0]        decim,
   input  logic              frame_done,
   output logic              ad_buf_wr,
   output logic [11:0]       ad_buf_wr_addr,
   output logic [DATA_W-1:0] ad_buf_data,
   output logic [11:0]       start_addr,
   output logic              capt_done,
   output logic              auto_trig
);

   localparam int DEPTH    = 2 ** ADDR_W;
   localparam int POST_LEN = DEPTH - PRE_TRIG;
   localparam int TCNT_W   = $clog2(TIMEOUT + 1);

   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
   localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);
   localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
   localparam logic [TCNT_W-1:0] TO_LAST   = TCNT_W'(TIMEOUT - 1);
   localparam logic [TCNT_W-1:0] TO_MAX    = TCNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_ARM,
      S_POST,
      S_HOLD
   } state_t;

   state_t              state;
   logic [9:0]          dcnt;
   logic [ADDR_W-1:0]   waddr;
   logic [ADDR_W-1:0]   pcnt;
   logic [TCNT_W-1:0]   tcnt;
   logic [DATA_W-1:0]   prev;
   logic                prev_valid;

   logic                sample_en;
   logic                in_acq;
   logic                edge_hit;
   logic                time_hit;
   logic [ADDR_W-1:0]   trig_start;

   assign sample_en  = (state != S_IDLE) && (dcnt == decim);
   assign in_acq     = state inside {S_PRE, S_ARM, S_POST};
   assign edge_hit   = prev_valid &&
                       (trig_edge ? (prev > trig_level && ad_data <= trig_level)
                                  : (prev < trig_level && ad_data >= trig_level));
   assign time_hit   = trig_auto && (tcnt == TO_LAST);
   assign trig_start = waddr - PRE_OFS;

   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         dcnt           <= '0;
         waddr          <= '0;
         pcnt           <= '0;
         tcnt           <= '0;
         prev           <= '0;
         prev_valid     <= 1'b0;
         ad_buf_wr      <= 1'b0;
         ad_buf_wr_addr <= '0;
         ad_buf_data    <= '0;
         start_addr     <= '0;
         capt_done      <= 1'b0;
         auto_trig      <= 1'b0;
      end else begin
         ad_buf_wr <= 1'b0;

         if (state == S_IDLE || sample_en) begin
            dcnt <= '0;
         end else begin
            dcnt <= dcnt + 1'b1;
         end

         if (state == S_IDLE) begin
            waddr      <= '0;
            pcnt       <= '0;
            tcnt       <= '0;
            prev_valid <= 1'b0;
            capt_done  <= 1'b0;
            if (run) begin
               state <= S_PRE;
            end
         end else if (!run) begin
            // abort wins over trigger and frame_done; any write already issued still lands
            state     <= S_IDLE;
            capt_done <= 1'b0;
         end else begin
            if (sample_en && in_acq) begin
               ad_buf_wr      <= 1'b1;
               ad_buf_wr_addr <= 12'(waddr);
               ad_buf_data    <= ad_data;
               waddr          <= waddr + 1'b1;
               prev           <= ad_data;
               prev_valid     <= 1'b1;
            end

            case (state)
               S_PRE: begin
                  if (sample_en) begin
                     if (pcnt == PRE_LAST) begin
                        state <= S_ARM;
                        pcnt  <= '0;
                        tcnt  <= '0;
                     end else begin
                        pcnt <= pcnt + 1'b1;
                     end
                  end
               end
               S_ARM: begin
                  if (sample_en) begin
                     if (edge_hit || time_hit) begin
                        start_addr <= 12'(trig_start);
                        auto_trig  <= !edge_hit;
                        pcnt       <= ADDR_W'(1);
                        state      <= S_POST;
                     end else if (tcnt != TO_MAX) begin
                        tcnt <= tcnt + 1'b1;
                     end
                  end
               end
               S_POST: begin
                  if (sample_en) begin
                     if (pcnt == POST_LAST) begin
                        state     <= S_HOLD;
                        capt_done <= 1'b1;
                     end else begin
                        pcnt <= pcnt + 1'b1;
                     end
                  end
               end
               S_HOLD: begin
                  if (frame_done) begin
                     state     <= S_PRE;
                     pcnt      <= '0;
                     tcnt      <= '0;
                     capt_done <= 1'b0;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// Randomized bench for ad_capture_ctrl: per-cycle comparison against a counting model of the
// capture rules, plus directed checks of ramp, decimation, auto timeout, falling edge and abort.
module tb_ad_capture_ctrl;

   localparam int DEPTH    = 1024;
   localparam int PRE_TRIG = 256;
   localparam int TIMEOUT  = 16;

   localparam int P_IDLE = 0;
   localparam int P_PRE  = 1;
   localparam int P_ARM  = 2;
   localparam int P_POST = 3;
   localparam int P_HOLD = 4;

   logic        ad_clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ad_data;
   logic        run;
   logic [7:0]  trig_level;
   logic        trig_edge;
   logic        trig_auto;
   logic [9:0]  decim;
   logic        frame_done;
   logic        ad_buf_wr;
   logic [11:0] ad_buf_wr_addr;
   logic [7:0]  ad_buf_data;
   logic [11:0] start_addr;
   logic        capt_done;
   logic        auto_trig;

   ad_capture_ctrl #(
      .DATA_W   (8),
      .ADDR_W   (10),
      .PRE_TRIG (PRE_TRIG),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .ad_clk         (ad_clk),
      .rst_n          (rst_n),
      .ad_data        (ad_data),
      .run            (run),
      .trig_level     (trig_level),
      .trig_edge      (trig_edge),
      .trig_auto      (trig_auto),
      .decim          (decim),
      .frame_done     (frame_done),
      .ad_buf_wr      (ad_buf_wr),
      .ad_buf_wr_addr (ad_buf_wr_addr),
      .ad_buf_data    (ad_buf_data),
      .start_addr     (start_addr),
      .capt_done      (capt_done),
      .auto_trig      (auto_trig)
   );

   always #5 ad_clk = ~ad_clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // reference model state
   int m_ph = P_IDLE, m_dc = 0, m_wa = 0, m_cnt = 0, m_tc = 0, m_prev = 0, m_pv = 0;
   int m_wr = 0, m_addr = 0, m_data = 0, m_start = 0, m_done = 0, m_auto = 0;

   // stimulus sources
   int src_mode = 0;
   int ramp     = 0;
   int cval     = 0;
   int seq[$];

   logic [7:0] dbuf [DEPTH];
   int dwr_cnt = 0;
   int cyc     = 0;

   task automatic model_edge();
      int  ph0, cur, lvl;
      bit  se, hit_e, hit_t;
      ph0   = m_ph;
      cur   = int'(ad_data);
      lvl   = int'(trig_level);
      se    = (ph0 != P_IDLE) && (m_dc == int'(decim));
      m_wr  = 0;
      hit_e = 0;
      hit_t = 0;
      if (ph0 == P_IDLE) begin
         m_dc   = 0;
         m_done = 0;
         if (run) begin
            m_ph  = P_PRE;
            m_wa  = 0;
            m_cnt = 0;
            m_tc  = 0;
            m_pv  = 0;
         end
      end else if (!run) begin
         m_ph   = P_IDLE;
         m_done = 0;
      end else begin
         m_dc = se ? 0 : (m_dc + 1) % 1024;
         if (se && ph0 != P_HOLD) begin
            m_wr   = 1;
            m_addr = m_wa;
            m_data = cur;
            m_wa   = (m_wa + 1) % DEPTH;
         end
         case (ph0)
            P_PRE: if (se) begin
               m_cnt++;
               if (m_cnt == PRE_TRIG) begin
                  m_ph = P_ARM;
                  m_tc = 0;
               end
            end
            P_ARM: if (se) begin
               m_tc++;
               hit_e = (m_pv != 0) && (trig_edge ? (m_prev > lvl && cur <= lvl)
                                                 : (m_prev < lvl && cur >= lvl));
               hit_t = trig_auto && (m_tc == TIMEOUT);
               if (hit_e || hit_t) begin
                  m_start = (m_addr - PRE_TRIG + DEPTH) % DEPTH;
                  m_auto  = hit_e ? 0 : 1;
                  m_cnt   = 1;
                  m_ph    = P_POST;
               end
            end
            P_POST: if (se) begin
               m_cnt++;
               if (m_cnt == DEPTH - PRE_TRIG) begin
                  m_ph   = P_HOLD;
                  m_done = 1;
               end
            end
            P_HOLD: if (frame_done) begin
               m_ph   = P_PRE;
               m_cnt  = 0;
               m_tc   = 0;
               m_done = 0;
            end
            default: ;
         endcase
         if (m_wr != 0) begin
            m_prev = cur;
            m_pv   = 1;
         end
      end
   endtask

   task automatic drive_data();
      int v;
      if (seq.size() > 0) begin
         v = seq.pop_front();
      end else begin
         case (src_mode)
            0: begin
               v    = ramp;
               ramp = (ramp + 1) % 256;
            end
            1:       v = cval;
            default: v = int'($urandom_range(0, 255));
         endcase
      end
      ad_data = 8'(v);
   endtask

   task automatic step();
      drive_data();
      model_edge();
      @(posedge ad_clk);
      #1;
      cyc++;
      check("wr", ad_buf_wr, m_wr);
      if (m_wr != 0) begin
         check("addr", ad_buf_wr_addr, m_addr);
         check("data", ad_buf_data, m_data);
      end
      check("capt_done", capt_done, m_done);
      check("start_addr", start_addr, m_start);
      check("auto_trig", auto_trig, m_auto);
      if (ad_buf_wr === 1'b1) begin
         dbuf[ad_buf_wr_addr[9:0]] = ad_buf_data;
         dwr_cnt++;
      end
   endtask

   task automatic wait_capt(input int budget, input string tag);
      int n;
      n = 0;
      while (capt_done !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check(tag, capt_done, 1);
   endtask

   task automatic wait_write(input int budget);
      int n;
      n = 0;
      while (ad_buf_wr !== 1'b1 && n < budget) begin
         step();
         n++;
      end
   endtask

   initial begin
      int idx, got, last_cyc, last_data;
      rst_n      = 1'b0;
      run        = 1'b0;
      ad_data    = '0;
      trig_level = 8'd100;
      trig_edge  = 1'b0;
      trig_auto  = 1'b0;
      decim      = '0;
      frame_done = 1'b0;

      repeat (3) @(posedge ad_clk);
      #1;
      check("rst_wr", ad_buf_wr, 0);
      check("rst_addr", ad_buf_wr_addr, 0);
      check("rst_data", ad_buf_data, 0);
      check("rst_start", start_addr, 0);
      check("rst_capt", capt_done, 0);
      check("rst_auto", auto_trig, 0);
      rst_n = 1'b1;

      // ramp starting so the first ARM sample is the 99->100 crossing
      src_mode = 0;
      ramp     = 99;
      dwr_cnt  = 0;
      run      = 1'b1;
      wait_capt(3000, "ramp_capt");
      check("ramp_start", start_addr, 0);
      check("ramp_writes", dwr_cnt, 1024);
      idx = (int'(start_addr) + PRE_TRIG) % DEPTH;
      check("ramp_trig_sample", dbuf[idx], 100);
      check("ramp_auto", auto_trig, 0);

      repeat (5) step();
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      wait_write(50);
      check("resume_addr", ad_buf_wr_addr, 0);
      wait_capt(3000, "frame2_capt");

      // decimation by 4
      run = 1'b0;
      step();
      step();
      decim    = 10'd3;
      run      = 1'b1;
      got      = 0;
      last_cyc = -1;
      last_data = 0;
      for (int n = 0; n < 200 && got < 20; n++) begin
         step();
         if (ad_buf_wr === 1'b1) begin
            if (last_cyc >= 0) begin
               check("dec_gap", cyc - last_cyc, 4);
               check("dec_step", (int'(ad_buf_data) - last_data + 256) % 256, 4);
            end
            last_cyc  = cyc;
            last_data = int'(ad_buf_data);
            got++;
         end
      end
      check("dec_writes_seen", got, 20);
      wait_capt(6000, "dec_capt");

      // auto-mode forced trigger on a flat input
      run = 1'b0;
      step();
      step();
      decim     = '0;
      trig_auto = 1'b1;
      trig_edge = 1'b0;
      src_mode  = 1;
      cval      = 50;
      dwr_cnt   = 0;
      run       = 1'b1;
      wait_capt(2000, "auto_capt");
      check("auto_flag", auto_trig, 1);
      check("auto_start", start_addr, 15);
      check("auto_writes", dwr_cnt, 1039);

      // normal mode, flat input never triggers
      run = 1'b0;
      step();
      step();
      trig_auto = 1'b0;
      dwr_cnt   = 0;
      run       = 1'b1;
      repeat (2000) step();
      check("noauto_capt", capt_done, 0);
      check("noauto_writes", dwr_cnt, 1999);

      // falling edge: 100,100 must not fire, 120,110,90 fires on 90
      run = 1'b0;
      step();
      step();
      trig_edge = 1'b1;
      cval      = 100;
      run       = 1'b1;
      for (int i = 0; i < 277; i++) begin
         frame_done = (i == 270);
         step();
      end
      frame_done = 1'b0;
      seq.push_back(120);
      seq.push_back(110);
      seq.push_back(90);
      cval = 90;
      repeat (3) step();
      check("fall_start", start_addr, 22);
      check("fall_auto", auto_trig, 0);

      // abort in the middle of POST
      repeat (100) step();
      run = 1'b0;
      step();
      check("drop_wr", ad_buf_wr, 0);
      check("drop_capt", capt_done, 0);
      step();
      step();
      run = 1'b1;
      wait_write(20);
      check("restart_addr", ad_buf_wr_addr, 0);

      for (int it = 0; it < 6; it++) begin
         run = 1'b0;
         step();
         step();
         decim      = 10'($urandom_range(0, 2));
         trig_edge  = 1'($urandom_range(0, 1));
         trig_level = 8'($urandom_range(20, 230));
         trig_auto  = 1'($urandom_range(0, 1));
         src_mode   = int'($urandom_range(0, 2));
         ramp       = int'($urandom_range(0, 255));
         cval       = int'($urandom_range(0, 255));
         for (int k = 0; k < 4000; k++) begin
            frame_done = ($urandom_range(0, 49) == 0);
            run        = ($urandom_range(0, 1999) != 0);
            step();
         end
      end
      frame_done = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
